rr_arbiter8: RTL

Eight-way round-robin arbiter that shares a single downstream resource between eight requesters and drives that resource's select lines as a 3-bit index and its one-hot decoded form. It sits in front of the shared datapath or bus and replaces per-requester enable logic. Grants are registered and held while the owner keeps requesting. Handover to the next requester takes zero idle cycles.

---
 rtl/rr_arbiter8.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot and indexed grant outputs.
// Optional forced rotation after MAX_HOLD grant cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
        $error("rr_arbiter8: MAX_HOLD must be in 2..256");
    end

    logic [0:0] state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] idx_r, idx_nx;
    logic [7:0] gnt_r;
    logic       new_grant;
    logic [3:0] sel;

    // Returns {found, index} of the first set bit scanning p, p+1, ... p+7 (mod 8).
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'b0;
        for (int i = 0; i < 8; i++) begin
            k = p + 3'(i);
            if (!res[3] && r[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    assign sel = pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] cnt;
    logic             expired;
    logic             force_rot;
    logic             timeout_r;
    logic [3:0]       sel_other;

    assign expired   = (cnt == CNT_W'(MAX_HOLD - 1));
    assign sel_other = pick(req & ~(8'h01 << idx_r), ptr);
`endif

    always_comb begin
        state_nx  = state;
        idx_nx    = idx_r;
        ptr_nx    = ptr;
        new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
        force_rot = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel[3]) begin
                    state_nx  = GRANT;
                    idx_nx    = sel[2:0];
                    new_grant = 1'b1;
                end
            end
            default: begin
                if (!req[idx_r]) begin
                    // The owner's bit is clear, so sel already excludes it.
                    if (sel[3]) begin
                        idx_nx    = sel[2:0];
                        new_grant = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (expired && sel_other[3]) begin
                    idx_nx    = sel_other[2:0];
                    new_grant = 1'b1;
                    force_rot = 1'b1;
                end
`endif
            end
        endcase
        if (new_grant) begin
            ptr_nx = idx_nx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            idx_r <= 3'd0;
            gnt_r <= 8'h00;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            idx_r <= idx_nx;
            gnt_r <= (state_nx == GRANT) ? (8'h01 << idx_nx) : 8'h00;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter clears on each new grant and saturates at MAX_HOLD-1 while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= force_rot;
            if (new_grant) begin
                cnt <= '0;
            end else if (state == GRANT && !expired) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_r;
    assign gnt_idx   = idx_r;
    assign gnt_valid = (state == GRANT);

endmodule
